// File: rtl/fetch_replay_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_replay_ctrl: fetch-stage PC owner, stall replay and redirect/drop  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_replay_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] fetch_inst,
  output logic        fetch_valid,
  output logic [15:0] fetch_pc_inc,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_PRESENT = 2'd1,
    S_DROP    = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          inst_d  = NOP;
          // An unanswered request must be drained before refetching.
          state_d = imem_valid ? S_FETCH : S_DROP;
        end else if (imem_valid) begin
          inst_d  = imem_rdata;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          inst_d  = NOP;
          state_d = S_FETCH;
        end else if (stall) begin
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else begin
          pc_d    = pc_q + 16'd2;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (halt) begin
          state_d = S_HALTED;
        end else begin
          if (redirect) begin
            pc_d = redirect_pc;
          end
          // The stale response retires the old request; a redirect in the
          // same cycle has no further response to wait for.
          if (imem_valid) begin
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= NOP;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign imem_req     = rst_n && (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign fetch_inst   = (state_q == S_PRESENT) ? inst_q : NOP;
  assign fetch_valid  = (state_q == S_PRESENT) && !redirect;
  assign fetch_pc_inc = pc_q + 16'd2;
  assign halted       = (state_q == S_HALTED);
  assign stall_cnt    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_replay_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_replay_ctrl: directed scenarios plus randomized model check     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_replay_ctrl;
  localparam logic [15:0] NOP_W = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt = 1'b0;
  logic [15:0] fetch_inst;
  logic        fetch_valid;
  logic [15:0] fetch_pc_inc;
  logic        halted;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  fetch_replay_ctrl #(.RESET_PC(16'h0000), .NOP(16'h0800)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
    .fetch_pc_inc(fetch_pc_inc), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] wordf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA55A ^ (a * 16'd3);
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", imem_addr); end
    checks++; if (fetch_inst !== NOP_W) begin errors++; $display("FAIL rst_inst got %h exp %h", fetch_inst, NOP_W); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", fetch_valid); end
    checks++; if (fetch_pc_inc !== 16'h0002) begin errors++; $display("FAIL rst_pcinc got %h exp 0002", fetch_pc_inc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL rst_cnt got %h exp 0000", stall_cnt); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
  endtask

  task automatic test_basic();
    imem_valid = 1'b1; imem_rdata = 16'hC123;
    cyc();
    imem_valid = 1'b0; imem_rdata = 16'h0000;
    checks++; if (fetch_inst !== 16'hC123) begin errors++; $display("FAIL basic_inst got %h exp C123", fetch_inst); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", fetch_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req got %b exp 0", imem_req); end
    checks++; if (fetch_pc_inc !== 16'h0002) begin errors++; $display("FAIL basic_pcinc got %h exp 0002", fetch_pc_inc); end
    cyc();
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL basic_next_addr got %h exp 0002", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_next_req got %b exp 1", imem_req); end
  endtask

  task automatic test_stall();
    imem_valid = 1'b1; imem_rdata = 16'hD8A4;
    cyc();
    imem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = (i < 3);
      checks++; if (fetch_inst !== 16'hD8A4) begin errors++; $display("FAIL stall_inst[%0d] got %h exp D8A4", i, fetch_inst); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, fetch_valid); end
      checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 0002", i, imem_addr); end
      cyc();
    end
    stall = 1'b0;
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
    checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL stall_next_addr got %h exp 0004", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_next_req got %b exp 1", imem_req); end
  endtask

  task automatic test_redirect_drop();
    // Redirect with data arriving the same cycle: data dropped, refetch.
    redirect = 1'b1; redirect_pc = 16'h0010; imem_valid = 1'b1; imem_rdata = 16'hBEEF;
    cyc();
    redirect = 1'b0; imem_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL rd_same_addr got %h exp 0010", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_same_req got %b exp 1", imem_req); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rd_same_valid got %b exp 0", fetch_valid); end
    // Request to 0x10 outstanding with 3-cycle latency; redirect to 0x40.
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL drop_addr got %h exp 0040", imem_addr); end
    cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_wait_req got %b exp 0", imem_req); end
    cyc();
    imem_valid = 1'b1; imem_rdata = 16'hDEAD;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL drop_ret_valid got %b exp 0", fetch_valid); end
    cyc();
    imem_valid = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_exit_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL drop_exit_addr got %h exp 0040", imem_addr); end
    checks++; if (fetch_valid !== 1'b0 || fetch_inst !== NOP_W) begin errors++; $display("FAIL drop_exit_inst got %h/%b exp %h/0", fetch_inst, fetch_valid, NOP_W); end
    // Second redirect while already draining overwrites the target.
    redirect = 1'b1; redirect_pc = 16'h0060;
    cyc();
    redirect_pc = 16'h0080;
    cyc();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0080) begin errors++; $display("FAIL drop2_addr got %h/%b exp 0080/0", imem_addr, imem_req); end
    imem_valid = 1'b1;
    cyc();
    imem_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL drop2_exit got %h/%b exp 0080/1", imem_addr, imem_req); end
  endtask

  task automatic test_redirect_stall();
    imem_valid = 1'b1; imem_rdata = 16'h1234;
    cyc();
    imem_valid = 1'b0;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL rs_pre_valid got %b exp 1", fetch_valid); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b exp 0", fetch_valid); end
    cyc();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (imem_addr !== 16'h0100 || imem_req !== 1'b1) begin errors++; $display("FAIL rs_addr got %h/%b exp 0100/1", imem_addr, imem_req); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL rs_cnt got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFE; imem_valid = 1'b1; imem_rdata = 16'h0000;
    cyc();
    redirect = 1'b0; imem_valid = 1'b0;
    checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr got %h exp FFFE", imem_addr); end
    checks++; if (fetch_pc_inc !== 16'h0000) begin errors++; $display("FAIL wrap_pcinc got %h exp 0000", fetch_pc_inc); end
    imem_valid = 1'b1; imem_rdata = 16'h2222;
    cyc();
    imem_valid = 1'b0;
    checks++; if (fetch_inst !== 16'h2222) begin errors++; $display("FAIL wrap_inst got %h exp 2222", fetch_inst); end
    cyc();
    checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got %h/%b exp 0000/1", imem_addr, imem_req); end
  endtask

  task automatic test_halt();
    imem_valid = 1'b1; imem_rdata = 16'h3333;
    cyc();
    imem_valid = 1'b0; halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    cyc();
    halt = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stall = 1'($urandom); redirect = 1'($urandom); redirect_pc = 16'($urandom);
      imem_valid = 1'($urandom); imem_rdata = 16'($urandom);
      #1;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_state[%0d] got halted=%b req=%b exp 1/0", i, halted, imem_req); end
      checks++; if (fetch_inst !== NOP_W || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_inst[%0d] got %h/%b exp %h/0", i, fetch_inst, fetch_valid, NOP_W); end
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL halt_cnt[%0d] got %0d exp 3", i, stall_cnt); end
      cyc();
    end
    stall = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_rst got halted=%b addr=%h req=%b exp 0/0000/0", halted, imem_addr, imem_req); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_restart got %h/%b exp 0000/1", imem_addr, imem_req); end
  endtask

  task automatic test_reset_in_drop();
    redirect = 1'b1; redirect_pc = 16'h0300;
    cyc();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0300) begin errors++; $display("FAIL rdrop_enter got %h/%b exp 0300/0", imem_addr, imem_req); end
    cyc();
    #2; rst_n = 1'b0; #1;
    checks++; if (imem_addr !== 16'h0000 || fetch_pc_inc !== 16'h0002) begin errors++; $display("FAIL rdrop_pc got %h/%h exp 0000/0002", imem_addr, fetch_pc_inc); end
    checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_inst !== NOP_W) begin errors++; $display("FAIL rdrop_out got req=%b valid=%b inst=%h exp 0/0/%h", imem_req, fetch_valid, fetch_inst, NOP_W); end
    checks++; if (stall_cnt !== 16'd0 || halted !== 1'b0) begin errors++; $display("FAIL rdrop_cnt got %0d/%b exp 0/0", stall_cnt, halted); end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  // Model: the PC the core should be fetching, whether a fetched word for it
  // is being held, and whether the memory's in-flight reply is stale.
  task automatic test_random();
    logic [15:0] exp_pc, exp_cnt, raddr, exp_inc;
    logic        have_word, busy, stale, vnow, red, exp_req;
    int          lat, consumed;
    exp_pc = 16'h0000; exp_cnt = 16'h0000; raddr = 16'h0;
    have_word = 1'b0; busy = 1'b0; stale = 1'b0; lat = 0; consumed = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy && imem_req) begin
        busy = 1'b1; raddr = imem_addr; lat = int'($urandom_range(0, 2));
      end
      vnow = busy && (lat == 0);
      imem_valid = vnow;
      imem_rdata = vnow ? wordf(raddr) : 16'($urandom);
      stall = ($urandom % 3) == 0;
      red = (($urandom % 12) == 0) && !(stale && vnow);
      redirect = red;
      redirect_pc = (($urandom % 8) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      #1;
      exp_req = !have_word && !stale;
      exp_inc = exp_pc + 16'd2;
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", n, imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", n, imem_addr, exp_pc); end
      end
      checks++; if (fetch_valid !== (have_word && !red)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, fetch_valid, have_word && !red); end
      if (have_word) begin
        checks++; if (fetch_inst !== wordf(exp_pc) || fetch_pc_inc !== exp_inc) begin errors++; $display("FAIL rnd_inst[%0d] got %h/%h exp %h/%h", n, fetch_inst, fetch_pc_inc, wordf(exp_pc), exp_inc); end
      end else begin
        checks++; if (fetch_inst !== NOP_W) begin errors++; $display("FAIL rnd_nop[%0d] got %h exp %h", n, fetch_inst, NOP_W); end
      end
      checks++; if (stall_cnt !== exp_cnt || halted !== 1'b0) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d/%b exp %0d/0", n, stall_cnt, halted, exp_cnt); end
      if (red) begin
        exp_pc = redirect_pc; have_word = 1'b0;
        if (busy && !vnow) stale = 1'b1;
      end else if (have_word) begin
        if (stall) begin
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end else begin
          have_word = 1'b0; exp_pc = exp_pc + 16'd2; consumed++;
        end
      end else if (vnow && !stale) begin
        have_word = 1'b1;
      end
      if (vnow) begin
        busy = 1'b0; stale = 1'b0;
      end else if (busy) begin
        lat--;
      end
      cyc();
    end
    stall = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
    checks++; if (consumed < 100) begin errors++; $display("FAIL rnd_progress got %0d exp >=100", consumed); end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    imem_valid = 1'b1; imem_rdata = 16'h5A5A;
    cyc();
    imem_valid = 1'b0; stall = 1'b1;
    repeat (65534) cyc();
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h exp FFFE", stall_cnt); end
    repeat (3) cyc();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max got %h exp FFFF", stall_cnt); end
    checks++; if (fetch_inst !== 16'h5A5A || imem_addr !== 16'h0000) begin errors++; $display("FAIL sat_hold got %h/%h exp 5A5A/0000", fetch_inst, imem_addr); end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_reset_in_drop();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
